// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned MD_STEPS = WIDTH;
    localparam int unsigned CNT_W    = $clog2(MD_STEPS);

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic              is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_ctl_if.sv
// Execute-stage handshake between the core and the multiply/divide sequencer.
interface muldiv_ctl_if;
    import muldiv_pkg::*;

    logic             Start_EX;
    logic [1:0]       Op_EX;
    logic [WIDTH-1:0] SrcA_EX;
    logic [WIDTH-1:0] SrcB_EX;
    logic             flush;
    logic             ReadHiLo_EX;
    logic             ReadSel_EX;
    logic [WIDTH-1:0] HiLoData_EX;
    logic             MdStall;
    logic             Busy;
    logic             Done;

    modport master (
        output Start_EX, Op_EX, SrcA_EX, SrcB_EX, flush, ReadHiLo_EX, ReadSel_EX,
        input  HiLoData_EX, MdStall, Busy, Done
    );

    modport slave (
        input  Start_EX, Op_EX, SrcA_EX, SrcB_EX, flush, ReadHiLo_EX, ReadSel_EX,
        output HiLoData_EX, MdStall, Busy, Done
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply step or restoring-divide step.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        trial       = '0;
        diff        = '0;
        if (is_div) begin
            // acc = {remainder, remaining dividend bits}; mplier holds the divisor
            trial = acc[2*WIDTH-1:WIDTH-1];
            diff  = trial - {1'b0, mplier};
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mplier[0]) begin
                acc_next = acc + mcand;
            end
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
        end
    end

endmodule

// File: rtl/muldiv_ctl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO and the execute-stage stall request.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module muldiv_ctl
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    muldiv_ctl_if.slave  bus
);

    md_state_e          state;
    md_op_e             op;
    logic               sign_a;
    logic               sign_b;
    logic               done;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0]   mplier_next;
    logic               is_div;
    logic               signed_req;
    logic               start_ok;
    logic               last_step;
    logic               early_out;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   dividend;

    muldiv_step u_step (
        .is_div      (is_div),
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    always_comb begin
        is_div     = op[1];
        signed_req = ~bus.Op_EX[0];
        start_ok   = bus.Start_EX && !bus.flush;
        last_step  = (count == CNT_W'(MD_STEPS - 1));
        mag_a      = magnitude(bus.SrcA_EX, signed_req);
        mag_b      = magnitude(bus.SrcB_EX, signed_req);
`ifdef MULDIV_EARLY_OUT_EN
        early_out  = !is_div && (mplier_next == '0);
`else
        early_out  = 1'b0;
`endif
        // Signs are only latched for signed ops, so unsigned results pass through unchanged
        prod_fix   = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        dividend   = sign_a ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op     <= MD_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= RUN;
                        op     <= md_op_e'(bus.Op_EX);
                        sign_a <= signed_req & bus.SrcA_EX[WIDTH-1];
                        sign_b <= signed_req & bus.SrcB_EX[WIDTH-1];
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= bus.Op_EX[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    count  <= count + 1'b1;
                    if (last_step || early_out) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (mplier == '0) begin
                            lo <= '1;
                            hi <= dividend;
                        end else begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy        = (state != IDLE);
    assign bus.Done        = done;
    assign bus.MdStall     = bus.Busy && (bus.Start_EX || bus.ReadHiLo_EX);
    assign bus.HiLoData_EX = bus.ReadSel_EX ? hi : lo;

endmodule

// File: tb/tb_muldiv_ctl.sv
// Self-checking bench for muldiv_ctl: directed vector table, random ops against an arithmetic
// reference model, and hand-written stall/flush/reset sequences.
module tb_muldiv_ctl;
    import muldiv_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctl_if bus ();

    muldiv_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating signed division as MIPS defines it
    function automatic void ref_md(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = op[0] ? longint'({32'h0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'h0, b}) : longint'($signed(b));
        if (!op[1]) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Cycles from the start edge until Done is seen
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int          k;
        bit          early;
        early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        early = 1'b1;
`endif
        m = (!op[0] && b[31]) ? -b : b;
        k = 1;
        m = m >> 1;
        while (m != 0) begin
            k++;
            m = m >> 1;
        end
        return (early && !op[1]) ? k + 1 : 33;
    endfunction

    function automatic logic [31:0] pick();
        unique case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output int lat);
        bus.Op_EX    = op;
        bus.SrcA_EX  = a;
        bus.SrcB_EX  = b;
        bus.Start_EX = 1'b1;
        @(posedge clk); #1;
        bus.Start_EX = 1'b0;
        lat = 0;
        while (!bus.Done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        bus.ReadSel_EX = 1'b1; #1;
        hi = bus.HiLoData_EX;
        bus.ReadSel_EX = 1'b0; #1;
        lo = bus.HiLoData_EX;
    endtask

    task automatic op_and_check(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ehi,
                                input logic [31:0] elo);
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        run_op(op, a, b, hi, lo, lat);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
        check({name, "_lat"}, lat, exp_lat(op, b));
        @(posedge clk); #1;
        check({name, "_done_pulse"}, {31'h0, bus.Done}, 32'h0);
    endtask

    initial begin
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] last_hi;
        logic [31:0] last_lo;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          stall;
        int          done_seen;

        bus.Start_EX    = 1'b0;
        bus.Op_EX       = 2'b00;
        bus.SrcA_EX     = '0;
        bus.SrcB_EX     = '0;
        bus.flush       = 1'b0;
        bus.ReadHiLo_EX = 1'b0;
        bus.ReadSel_EX  = 1'b0;

        vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F};
        vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

        // Held in reset: even a start request must not make the unit busy
        repeat (2) @(posedge clk);
        #1;
        bus.Start_EX = 1'b1;
        bus.ReadHiLo_EX = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", {31'h0, bus.Busy}, 32'h0);
        check("rst_done", {31'h0, bus.Done}, 32'h0);
        check("rst_stall", {31'h0, bus.MdStall}, 32'h0);
        bus.ReadSel_EX = 1'b1; #1;
        check("rst_hi", bus.HiLoData_EX, 32'h0);
        bus.ReadSel_EX = 1'b0; #1;
        check("rst_lo", bus.HiLoData_EX, 32'h0);
        bus.Start_EX = 1'b0;
        bus.ReadHiLo_EX = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            op_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].hi, vecs[i].lo);
        end

        last_hi = vecs[7].hi;
        last_lo = vecs[7].lo;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            ref_md(rop, ra, rb, ehi, elo);
            op_and_check($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), rop, ra, rb, ehi, elo);
            last_hi = ehi;
            last_lo = elo;
        end

        // Start and read together while idle: old LO is returned, no stall, start is taken
        bus.ReadHiLo_EX = 1'b1;
        bus.ReadSel_EX  = 1'b0;
        bus.Op_EX       = 2'b11;
        bus.SrcA_EX     = 32'd1000;
        bus.SrcB_EX     = 32'd7;
        bus.Start_EX    = 1'b1;
        #1;
        check("idle_read_old_lo", bus.HiLoData_EX, last_lo);
        check("idle_start_nostall", {31'h0, bus.MdStall}, 32'h0);
        @(posedge clk); #1;
        bus.Start_EX   = 1'b0;
        bus.ReadSel_EX = 1'b1;
        check("start_taken_busy", {31'h0, bus.Busy}, 32'h1);
        check("mfhi_old_hi_during_run", bus.HiLoData_EX, last_hi);

        // MFHI from E1 stalls; a second start plus a flush arrive mid-run and must not matter
        stall = 0;
        while (bus.MdStall && stall < 100) begin
            stall++;
            if (stall == 5) begin
                bus.Op_EX    = 2'b01;
                bus.SrcA_EX  = 32'd3;
                bus.SrcB_EX  = 32'd3;
                bus.Start_EX = 1'b1;
                bus.flush    = 1'b1;
            end
            @(posedge clk); #1;
            bus.Start_EX = 1'b0;
            bus.flush    = 1'b0;
        end
        check("mfhi_stall_cycles", stall, 33);
        check("mfhi_done", {31'h0, bus.Done}, 32'h1);
        check("mfhi_new_hi", bus.HiLoData_EX, 32'd6);
        bus.ReadSel_EX = 1'b0; #1;
        check("div_new_lo", bus.HiLoData_EX, 32'd142);
        bus.ReadHiLo_EX = 1'b0;
        @(posedge clk); #1;
        check("held_start_dropped", {31'h0, bus.Busy}, 32'h0);

        // Start squashed by flush while idle
        bus.Op_EX    = 2'b00;
        bus.SrcA_EX  = 32'd9;
        bus.SrcB_EX  = 32'd9;
        bus.Start_EX = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk); #1;
        bus.Start_EX = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_no_start", {31'h0, bus.Busy}, 32'h0);

        // Reset at E10 of a MULT
        bus.Op_EX    = 2'b00;
        bus.SrcA_EX  = 32'h0000_0007;
        bus.SrcB_EX  = 32'hFFFF_FFFD;
        bus.Start_EX = 1'b1;
        @(posedge clk); #1;
        bus.Start_EX = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        reset = 1'b0;
        bus.ReadHiLo_EX = 1'b1;
        #1;
        check("midrst_busy", {31'h0, bus.Busy}, 32'h0);
        check("midrst_stall", {31'h0, bus.MdStall}, 32'h0);
        check("midrst_done", {31'h0, bus.Done}, 32'h0);
        bus.ReadSel_EX = 1'b1; #1;
        check("midrst_hi", bus.HiLoData_EX, 32'h0);
        bus.ReadSel_EX = 1'b0; #1;
        check("midrst_lo", bus.HiLoData_EX, 32'h0);
        bus.ReadHiLo_EX = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.Done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_idle_after", {31'h0, bus.Busy}, 32'h0);

        // Unit still works after the abort
        op_and_check("post_rst", 2'b01, 32'd5, 32'd3, 32'd0, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
